// File: rtl/lcd_timing_gen.sv
// Raster timing generator: programmable H/V fields, frame-boundary shadowed timing set,
// graceful end-of-frame stop, prefetch strobe leading data-enable by LEAD clocks.
module lcd_timing_gen #(
    parameter int HW   = 11,
    parameter int VW   = 11,
    parameter int LEAD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [HW-1:0] cfg_hsw,
    input  logic [HW-1:0] cfg_hbp,
    input  logic [HW-1:0] cfg_hact,
    input  logic [HW-1:0] cfg_hfp,
    input  logic [VW-1:0] cfg_vsw,
    input  logic [VW-1:0] cfg_vbp,
    input  logic [VW-1:0] cfg_vact,
    input  logic [VW-1:0] cfg_vfp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    input  logic          cfg_depol,
    input  logic [VW-1:0] cfg_irq_line,
    input  logic          cfg_update,
    output logic          cfg_ack,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          pipe,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          frame_start,
    output logic          line_irq,
    output logic          busy
);

    localparam int HC = HW + 2;
    localparam int VC = VW + 2;
    localparam logic [HC-1:0] HLEAD = HC'(LEAD);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [HW-1:0] sh_hsw, sh_hbp, sh_hact, sh_hfp;
    logic [VW-1:0] sh_vsw, sh_vbp, sh_vact, sh_vfp;
    logic          sh_hpol, sh_vpol, sh_depol;
    logic          pending;
    logic [HC-1:0] hcnt;
    logic [VC-1:0] vcnt;

    logic [HC-1:0] hsw_l, hbp_l, hact_l, hfp_l, htotal, hstart, hend, pstart, pend;
    logic [VC-1:0] vsw_l, vbp_l, vact_l, vfp_l, vtotal, vstart, vend;
    logic          running, h_last, v_last, frame_end, load;
    logic          hs_i, vs_i, hact_i, vact_i, de_i, pipe_i;

    // Field lengths are stored minus one, so a length can never be zero.
    assign hsw_l  = HC'(sh_hsw)  + HC'(1);
    assign hbp_l  = HC'(sh_hbp)  + HC'(1);
    assign hact_l = HC'(sh_hact) + HC'(1);
    assign hfp_l  = HC'(sh_hfp)  + HC'(1);
    assign vsw_l  = VC'(sh_vsw)  + VC'(1);
    assign vbp_l  = VC'(sh_vbp)  + VC'(1);
    assign vact_l = VC'(sh_vact) + VC'(1);
    assign vfp_l  = VC'(sh_vfp)  + VC'(1);

    assign htotal = hsw_l + hbp_l + hact_l + hfp_l;
    assign vtotal = vsw_l + vbp_l + vact_l + vfp_l;
    assign hstart = hsw_l + hbp_l;
    assign hend   = hstart + hact_l;
    assign vstart = vsw_l + vbp_l;
    assign vend   = vstart + vact_l;
    assign pstart = (hstart > HLEAD) ? hstart - HLEAD : '0;
    assign pend   = (hend > HLEAD) ? hend - HLEAD : '0;

    assign hs_i   = hcnt < hsw_l;
    assign vs_i   = vcnt < vsw_l;
    assign hact_i = (hcnt >= hstart) && (hcnt < hend);
    assign vact_i = (vcnt >= vstart) && (vcnt < vend);
    assign de_i   = hact_i && vact_i;
    assign pipe_i = vact_i && (hcnt >= pstart) && (hcnt < pend);

    assign running   = (state != IDLE);
    assign h_last    = (hcnt == htotal - HC'(1));
    assign v_last    = (vcnt == vtotal - VC'(1));
    assign frame_end = running && h_last && v_last;
    // Loading only at frame end (or while stopped) keeps each frame on one timing set.
    assign load      = pending && (!running || frame_end);
    assign cfg_ack   = load;
    assign busy      = running;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= 1'b0;
            sh_hsw   <= '0;
            sh_hbp   <= '0;
            sh_hact  <= '0;
            sh_hfp   <= '0;
            sh_vsw   <= '0;
            sh_vbp   <= '0;
            sh_vact  <= '0;
            sh_vfp   <= '0;
            sh_hpol  <= 1'b1;
            sh_vpol  <= 1'b1;
            sh_depol <= 1'b1;
        end else begin
            pending <= cfg_update || (pending && !load);
            if (load) begin
                sh_hsw   <= cfg_hsw;
                sh_hbp   <= cfg_hbp;
                sh_hact  <= cfg_hact;
                sh_hfp   <= cfg_hfp;
                sh_vsw   <= cfg_vsw;
                sh_vbp   <= cfg_vbp;
                sh_vact  <= cfg_vact;
                sh_vfp   <= cfg_vfp;
                sh_hpol  <= cfg_hpol;
                sh_vpol  <= cfg_vpol;
                sh_depol <= cfg_depol;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            pipe        <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            line_irq    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (en) state <= RUN;
                end
                RUN, DRAIN: begin
                    if (h_last) begin
                        hcnt <= '0;
                        vcnt <= v_last ? '0 : vcnt + VC'(1);
                    end else begin
                        hcnt <= hcnt + HC'(1);
                    end
                    if (state == RUN) begin
                        if (!en) state <= DRAIN;
                    end else if (en) begin
                        state <= RUN;
                    end else if (frame_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (running) begin
                hsync       <= ~(hs_i ^ sh_hpol);
                vsync       <= ~(vs_i ^ sh_vpol);
                de          <= ~(de_i ^ sh_depol);
                pipe        <= pipe_i;
                pixel_x     <= de_i ? HW'(hcnt - hstart) : '0;
                pixel_y     <= de_i ? VW'(vcnt - vstart) : '0;
                frame_start <= (hcnt == '0) && (vcnt == '0);
                line_irq    <= (hcnt == '0) && (vcnt == VC'(cfg_irq_line));
            end else begin
                hsync       <= ~sh_hpol;
                vsync       <= ~sh_vpol;
                de          <= ~sh_depol;
                pipe        <= 1'b0;
                pixel_x     <= '0;
                pixel_y     <= '0;
                frame_start <= 1'b0;
                line_irq    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: frame-position reference model checked every cycle,
// plus directed literal expectations for the basic, update, stop, irq, polarity and reset cases.
module tb_lcd_timing_gen;

    localparam int HW = 11;
    localparam int VW = 11;
    localparam int LEAD = 2;

    logic clk = 1'b0;
    logic reset, en, cfg_update;
    logic [HW-1:0] cfg_hsw, cfg_hbp, cfg_hact, cfg_hfp;
    logic [VW-1:0] cfg_vsw, cfg_vbp, cfg_vact, cfg_vfp, cfg_irq_line;
    logic cfg_hpol, cfg_vpol, cfg_depol;
    logic cfg_ack, hsync, vsync, de, pipe, frame_start, line_irq, busy;
    logic [HW-1:0] pixel_x;
    logic [VW-1:0] pixel_y;

    always #5 clk = ~clk;

    lcd_timing_gen #(.HW(HW), .VW(VW), .LEAD(LEAD)) dut (
        .clk(clk), .reset(reset), .en(en),
        .cfg_hsw(cfg_hsw), .cfg_hbp(cfg_hbp), .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp),
        .cfg_vsw(cfg_vsw), .cfg_vbp(cfg_vbp), .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_depol(cfg_depol),
        .cfg_irq_line(cfg_irq_line), .cfg_update(cfg_update), .cfg_ack(cfg_ack),
        .hsync(hsync), .vsync(vsync), .de(de), .pipe(pipe),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .line_irq(line_irq), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Reference model: a single frame-position index, decoded with div/mod into (h,v).
    int s_len[8];
    bit s_pol[3];
    bit m_act, m_stop, m_pend;
    int m_t;
    bit e_hs, e_vs, e_de, e_pp, e_fs, e_li;
    int e_px, e_py;

    function automatic int m_tot();
        return (s_len[0] + s_len[1] + s_len[2] + s_len[3]) *
               (s_len[4] + s_len[5] + s_len[6] + s_len[7]);
    endfunction

    function automatic bit m_ack();
        return m_pend && (!m_act || m_t == m_tot() - 1);
    endfunction

    task automatic m_init();
        s_len = '{default: 1};
        s_pol = '{default: 1'b1};
        m_act = 0; m_stop = 0; m_pend = 0; m_t = 0;
        e_hs = 0; e_vs = 0; e_de = 0; e_pp = 0; e_fs = 0; e_li = 0;
        e_px = 0; e_py = 0;
    endtask

    task automatic m_step();
        int ht, vt, h, v, hst, vst, pst, pnd;
        bit ha, va, fe, ld;
        ht = s_len[0] + s_len[1] + s_len[2] + s_len[3];
        vt = s_len[4] + s_len[5] + s_len[6] + s_len[7];
        h = m_t % ht;
        v = m_t / ht;
        hst = s_len[0] + s_len[1];
        vst = s_len[4] + s_len[5];
        ha = (h >= hst) && (h < hst + s_len[2]);
        va = (v >= vst) && (v < vst + s_len[6]);
        pst = (hst > LEAD) ? hst - LEAD : 0;
        pnd = hst + s_len[2] - LEAD;
        if (m_act) begin
            e_hs = ((h < s_len[0]) == s_pol[0]);
            e_vs = ((v < s_len[4]) == s_pol[1]);
            e_de = ((ha && va) == s_pol[2]);
            e_pp = va && (h >= pst) && (h < pnd);
            e_px = (ha && va) ? h - hst : 0;
            e_py = (ha && va) ? v - vst : 0;
            e_fs = (m_t == 0);
            e_li = (h == 0) && (v == int'(cfg_irq_line));
        end else begin
            e_hs = !s_pol[0]; e_vs = !s_pol[1]; e_de = !s_pol[2];
            e_pp = 0; e_px = 0; e_py = 0; e_fs = 0; e_li = 0;
        end
        fe = m_act && (m_t == ht * vt - 1);
        ld = m_pend && (!m_act || fe);
        if (ld) begin
            s_len[0] = int'(cfg_hsw) + 1;  s_len[1] = int'(cfg_hbp) + 1;
            s_len[2] = int'(cfg_hact) + 1; s_len[3] = int'(cfg_hfp) + 1;
            s_len[4] = int'(cfg_vsw) + 1;  s_len[5] = int'(cfg_vbp) + 1;
            s_len[6] = int'(cfg_vact) + 1; s_len[7] = int'(cfg_vfp) + 1;
            s_pol[0] = cfg_hpol; s_pol[1] = cfg_vpol; s_pol[2] = cfg_depol;
        end
        m_pend = cfg_update || (m_pend && !ld);
        if (!m_act) begin
            if (en) begin m_act = 1; m_stop = 0; m_t = 0; end
        end else begin
            m_t = fe ? 0 : m_t + 1;
            if (m_stop) begin
                if (en) m_stop = 0;
                else if (fe) begin m_act = 0; m_t = 0; end
            end else if (!en) begin
                m_stop = 1;
            end
        end
    endtask

    initial begin
        m_init();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_init();
            else m_step();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_chk++;
            if ({hsync, vsync, de, pipe, frame_start, line_irq, busy, cfg_ack} !==
                {e_hs, e_vs, e_de, e_pp, e_fs, e_li, m_act, m_ack()} ||
                int'(pixel_x) != e_px || int'(pixel_y) != e_py)
                $display("FAIL cycle_model t=%0t: actual hs%b vs%b de%b pp%b fs%b li%b busy%b ack%b x%0d y%0d required hs%b vs%b de%b pp%b fs%b li%b busy%b ack%b x%0d y%0d",
                         $time, hsync, vsync, de, pipe, frame_start, line_irq, busy, cfg_ack,
                         pixel_x, pixel_y, e_hs, e_vs, e_de, e_pp, e_fs, e_li, m_act, m_ack(),
                         e_px, e_py);
            else n_pass++;
        end
    end

    int now;
    int c_de, c_de0, c_pp, c_fs, c_li, c_ack, ack_at;

    task automatic clr();
        c_de = 0; c_de0 = 0; c_pp = 0; c_fs = 0; c_li = 0; c_ack = 0; ack_at = -1;
    endtask

    task automatic step();
        @(negedge clk);
        now++;
        if (de) c_de++; else c_de0++;
        if (pipe) c_pp++;
        if (frame_start) c_fs++;
        if (line_irq) c_li++;
        if (cfg_ack) begin c_ack++; ack_at = now; end
    endtask

    initial begin
        int k;
        reset = 0; en = 0; cfg_update = 0;
        cfg_hsw = 11'd1; cfg_hbp = 11'd2; cfg_hact = 11'd3; cfg_hfp = 11'd0;
        cfg_vsw = 11'd0; cfg_vbp = 11'd1; cfg_vact = 11'd2; cfg_vfp = 11'd0;
        cfg_hpol = 1; cfg_vpol = 1; cfg_depol = 1; cfg_irq_line = 11'd4;
        now = 0; clr();
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({hsync, vsync, de, pipe, busy, cfg_ack, frame_start, line_irq}), 0);
        chk("reset_pix", int'(pixel_x) + int'(pixel_y), 0);
        chk_on = 1;
        reset = 1;
        @(negedge clk);

        // Load the basic set while stopped.
        cfg_update = 1; step(); cfg_update = 0;
        chk("idle_ack", int'(cfg_ack), 1);
        step();
        chk("idle_ack_once", int'(cfg_ack), 0);

        // Basic frame, mid-frame update, second frame, graceful stop in frame three.
        clr(); en = 1; now = -1; step();
        while (now < 238) begin
            step();
            case (now)
                1: begin
                    chk("fs_first", int'(frame_start), 1);
                    chk("hs_first", int'(hsync), 1);
                    chk("vs_first", int'(vsync), 1);
                end
                3: chk("hs_off", int'(hsync), 0);
                20: begin cfg_hact = 11'd7; cfg_update = 1; end
                21: cfg_update = 0;
                36: begin
                    chk("de_first", int'(de), 1);
                    chk("px_first", int'(pixel_x), 0);
                    chk("py_first", int'(pixel_y), 0);
                end
                59: begin
                    chk("de_last", int'(de), 1);
                    chk("px_last", int'(pixel_x), 3);
                    chk("py_last", int'(pixel_y), 2);
                end
                70: begin
                    chk("f1_de", c_de, 12);
                    chk("f1_pipe", c_pp, 12);
                    chk("f1_li", c_li, 1);
                    chk("f1_ack_at", ack_at, 69);
                    chk("f1_ack_n", c_ack, 1);
                    clr();
                end
                100: begin cfg_hact = 11'd3; cfg_update = 1; end
                101: cfg_update = 0;
                168: begin
                    chk("f2_de", c_de, 24);
                    chk("f2_ack_at", ack_at, 167);
                    chk("f2_fs", c_fs, 1);
                    chk("f2_li", c_li, 1);
                    clr();
                end
                198: en = 0;
                237: chk("drain_busy", int'(busy), 1);
                238: chk("stop_busy", int'(busy), 0);
                default: ;
            endcase
        end
        repeat (5) step();
        chk("f3_de", c_de, 12);
        chk("f3_fs", c_fs, 1);
        chk("f3_li", c_li, 1);
        chk("idle_hs", int'(hsync), 0);
        chk("idle_de", int'(de), 0);

        // One-cycle en runs exactly one frame; irq line beyond vtotal never fires.
        cfg_irq_line = 11'd9;
        clr(); en = 1; now = -1; step(); en = 0;
        while (now < 75) begin
            step();
            if (now == 69) chk("pulse_busy", int'(busy), 1);
            if (now == 70) chk("pulse_idle", int'(busy), 0);
        end
        chk("irq9_li", c_li, 0);
        chk("pulse_fs", c_fs, 1);
        chk("pulse_de", c_de, 12);

        // Active-low hsync and de.
        cfg_hpol = 0; cfg_depol = 0; cfg_update = 1; step(); cfg_update = 0;
        chk("pol_ack", int'(cfg_ack), 1);
        step(); step();
        chk("pol_idle_hs", int'(hsync), 1);
        chk("pol_idle_de", int'(de), 1);
        chk("pol_idle_vs", int'(vsync), 0);
        en = 1; now = -1; step(); en = 0; clr();
        while (now < 72) begin
            step();
            if (now == 1) begin
                chk("pol_hs_act", int'(hsync), 0);
                chk("pol_fs", int'(frame_start), 1);
            end
            if (now == 3) chk("pol_hs_inact", int'(hsync), 1);
            if (now == 36) chk("pol_de_act", int'(de), 0);
            if (now == 70) chk("pol_de_n", c_de0, 12);
        end
        chk("pol_end_de", int'(de), 1);

        // Asynchronous reset in the middle of active line 4.
        clr(); en = 1; now = -1; step();
        while (now < 47) step();
        chk("pre_rst_de", int'(de), 0);
        chk("pre_rst_px", int'(pixel_x), 1);
        #3 reset = 0;
        #1;
        chk("async_rst", int'({hsync, vsync, de, pipe, busy, cfg_ack, frame_start, line_irq}), 0);
        chk("async_rst_pix", int'(pixel_x) + int'(pixel_y), 0);
        en = 0;
        @(negedge clk);
        reset = 1;
        cfg_hpol = 1; cfg_depol = 1; cfg_irq_line = 11'd4;
        cfg_update = 1; step(); cfg_update = 0;
        chk("rst_reload_ack", int'(cfg_ack), 1);
        step();
        clr(); en = 1; now = -1; step();
        while (now < 70) begin
            step();
            if (now == 1) begin
                chk("restart_fs", int'(frame_start), 1);
                chk("restart_hs", int'(hsync), 1);
            end
        end
        chk("restart_de", c_de, 12);
        en = 0;
        k = 0;
        while (busy && k < 200) begin step(); k++; end
        chk("drain_done", int'(busy), 0);

        chk_on = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
